// File: rtl/led_scanner_if.sv
// ---------------------------------------------------------------------------
// led_scanner_if
//   Control and status bundle for the LED scanner.
//   Signals:
//     enable  1 = prescaler runs, 0 = freeze
//     mode    00 bounce, 01 rotate left, 10 rotate right, 11 hold
//     load    synchronous restart pulse
//     leds    LED pattern (WIDTH bits)
//     pos     current lit index
//     dir     1 = moving toward MSB
//     wrap    one-cycle pulse on end reversal / rotate wrap
//   Modports: master drives the controls, slave is the scanner itself.
// ---------------------------------------------------------------------------
interface led_scanner_if #(
   parameter int WIDTH = 18
);
   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             enable;
   logic [1:0]       mode;
   logic             load;
   logic [WIDTH-1:0] leds;
   logic [PW-1:0]    pos;
   logic             dir;
   logic             wrap;

   modport master (output enable, mode, load, input leds, pos, dir, wrap);
   modport slave  (input enable, mode, load, output leds, pos, dir, wrap);
endinterface

// File: rtl/led_scanner.sv
// ---------------------------------------------------------------------------
// led_scanner
//   One lit LED walks across a WIDTH-bit bar: bounce, rotate left/right or
//   hold, paced by a prescaler of DIV clocks per step.
//   Ports:
//     clock    system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      led_scanner_if.slave (enable, mode, load -> leds, pos, dir, wrap)
//   Parameters: WIDTH (>=2), DIV (>=1), TRAIL (>=1, trail build only)
//   Build option: define LED_SCAN_TRAIL_EN to light the last TRAIL positions
//   as a trail behind the current LED.
// ---------------------------------------------------------------------------
module led_scanner #(
   parameter int WIDTH = 18,
   parameter int DIV   = 50_000_000,
   parameter int TRAIL = 2
) (
   input  logic          clock,
   input  logic          reset_n,
   led_scanner_if.slave  bus
);
   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'b00,
      MODE_ROT_L  = 2'b01,
      MODE_ROT_R  = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_t;

   logic [CW-1:0] cnt_reg,  cnt_next;
   logic [PW-1:0] pos_reg,  pos_next;
   logic          dir_reg,  dir_next;
   logic          wrap_reg, wrap_next;
   logic          tick;
   logic          shift;
   mode_t         mode_sel;

   assign mode_sel = mode_t'(bus.mode);
   assign tick     = bus.enable && (cnt_reg == CW'(DIV - 1));
   // History only advances when the position actually moves.
   assign shift    = tick && !bus.load && (mode_sel != MODE_HOLD);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg  <= '0;
         pos_reg  <= POS_MAX;
         dir_reg  <= 1'b0;
         wrap_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         pos_reg  <= pos_next;
         dir_reg  <= dir_next;
         wrap_reg <= wrap_next;
      end
   end

   always_comb begin
      cnt_next  = cnt_reg;
      pos_next  = pos_reg;
      dir_next  = dir_reg;
      wrap_next = 1'b0;
      if (bus.load) begin
         // Restart wins over a coincident tick.
         cnt_next = '0;
         pos_next = POS_MAX;
         dir_next = 1'b0;
      end else if (tick) begin
         cnt_next = '0;
         unique case (mode_sel)
            MODE_BOUNCE: begin
               // Reverse and step on the same tick: end LEDs get no dwell.
               if (!dir_reg) begin
                  if (pos_reg == '0) begin
                     pos_next  = PW'(1);
                     dir_next  = 1'b1;
                     wrap_next = 1'b1;
                  end else begin
                     pos_next = pos_reg - PW'(1);
                  end
               end else begin
                  if (pos_reg == POS_MAX) begin
                     pos_next  = PW'(WIDTH - 2);
                     dir_next  = 1'b0;
                     wrap_next = 1'b1;
                  end else begin
                     pos_next = pos_reg + PW'(1);
                  end
               end
            end
            MODE_ROT_L: begin
               dir_next = 1'b1;
               if (pos_reg == POS_MAX) begin
                  pos_next  = '0;
                  wrap_next = 1'b1;
               end else begin
                  pos_next = pos_reg + PW'(1);
               end
            end
            MODE_ROT_R: begin
               dir_next = 1'b0;
               if (pos_reg == '0) begin
                  pos_next  = POS_MAX;
                  wrap_next = 1'b1;
               end else begin
                  pos_next = pos_reg - PW'(1);
               end
            end
            default: ; // hold: prescaler runs, position frozen
         endcase
      end else if (bus.enable) begin
         cnt_next = cnt_reg + CW'(1);
      end
   end

   logic [WIDTH-1:0] leds_c;

`ifdef LED_SCAN_TRAIL_EN
   // Entry 0 is the most recent previous position.
   logic [PW-1:0]    hist_pos_reg [TRAIL];
   logic [TRAIL-1:0] hist_vld_reg;

   genvar gi, gj;
   generate
      for (gi = 0; gi < TRAIL; gi++) begin : g_hist
         logic [PW-1:0] src_pos;
         logic          src_vld;
         if (gi == 0) begin : g_head
            assign src_pos = pos_reg;
            assign src_vld = 1'b1;
         end else begin : g_tail
            assign src_pos = hist_pos_reg[gi-1];
            assign src_vld = hist_vld_reg[gi-1];
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               hist_pos_reg[gi] <= '0;
               hist_vld_reg[gi] <= 1'b0;
            end else if (bus.load) begin
               hist_vld_reg[gi] <= 1'b0;
            end else if (shift) begin
               hist_pos_reg[gi] <= src_pos;
               hist_vld_reg[gi] <= src_vld;
            end
         end
      end

      for (gi = 0; gi < WIDTH; gi++) begin : g_led
         logic [TRAIL-1:0] hit;
         for (gj = 0; gj < TRAIL; gj++) begin : g_hit
            assign hit[gj] = hist_vld_reg[gj] && (hist_pos_reg[gj] == PW'(gi));
         end
         assign leds_c[gi] = (pos_reg == PW'(gi)) || (|hit);
      end
   endgenerate
`else
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_led
         assign leds_c[gi] = (pos_reg == PW'(gi));
      end
   endgenerate
`endif

   assign bus.leds = leds_c;
   assign bus.pos  = pos_reg;
   assign bus.dir  = dir_reg;
   assign bus.wrap = wrap_reg;
endmodule
